lock_track_controller: RTL and testbench
========================================

Name: lock_track_controller

Overview:
- Per-frame lock-on state machine between the target tracker (centroid result, `calc_done` strobe) and the HUD/status logic.
- Qualifies raw centroid results with acquisition hysteresis, a jump gate and coast-on-miss, then publishes a smoothed track position and lock status.
- Replaces direct use of raw `target_valid` for lock indication.
- Runs in the 25 MHz system clock domain.

Parameters:
- ACQ_FRAMES, 8: consecutive gated hits needed in ACQUIRE to declare lock. Legal 2..15.
- LOST_FRAMES, 4: consecutive misses while locked before the lock is dropped. Legal 2..15.
- MAX_JUMP, 12: max per-axis distance, in QQVGA pixels, between a new target and the current track for it to count as a hit. Legal 0..127.

Ports:
- clk  input  1  system clock (25 MHz).
- reset  input  1  synchronous, active-high reset.
- enable  input  1  tracking enable; low forces SEARCH.
- force_release  input  1  single-cycle request to drop the lock.
- calc_done  input  1  single-cycle pulse: per-frame target result valid this cycle.
- target_valid  input  1  tracker found a target (sampled only with calc_done).
- target_x  input  8  target X, 0..159 (sampled with calc_done).
- target_y  input  7  target Y, 0..119 (sampled with calc_done).
- lock_state  output  2  0=SEARCH, 1=ACQUIRE, 2=LOCKED, 3=COAST.
- lock_on  output  1  high in LOCKED or COAST.
- track_valid  output  1  high in any state except SEARCH.
- track_x  output  8  published track X.
- track_y  output  7  published track Y.
- lock_event  output  1  one-cycle pulse on entry to LOCKED from ACQUIRE.
- lost_event  output  1  one-cycle pulse on exit from LOCKED/COAST to SEARCH.
- locked_frames  output  16  count of calc_done frames evaluated while lock_on; saturates at 16'hFFFF.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: all outputs and internal counters are 0 (state SEARCH).
- Registered outputs: every output changes on the edge after the qualifying input cycle (1-cycle latency).
- Input priority within a cycle: reset > enable low > force_release > calc_done.
- enable low:
  - Next state SEARCH; acq_cnt and miss_cnt clear; track_x/track_y hold their last value.
  - lost_event and lock_event are NOT pulsed.
  - locked_frames holds.
- force_release high (enable high):
  - Next state SEARCH; counters clear.
  - lost_event pulses if the current state is LOCKED or COAST.
  - A calc_done in the same cycle is ignored.
- hit definition: target_valid && |target_x - track_x| <= MAX_JUMP && |target_y - track_y| <= MAX_JUMP.
  - Differences are computed unsigned-safe at 9 bits.
  - In SEARCH, any target_valid counts as a hit (no gate).
- Frame evaluation: occurs only on cycles with calc_done=1, enable=1 and force_release=0.
- SEARCH:
  - hit -> ACQUIRE; acq_cnt=1; track <= target (raw copy).
  - miss -> stay.
- ACQUIRE:
  - hit -> track <= target (raw); acq_cnt+1. If acq_cnt+1 == ACQ_FRAMES -> LOCKED, lock_event pulse, acq_cnt clears.
  - miss -> SEARCH; acq_cnt=0. Track holds; track_valid drops.
- LOCKED:
  - hit -> stay; track smoothed.
  - miss -> COAST; miss_cnt=1; track holds.
- COAST:
  - hit -> LOCKED; miss_cnt=0; track smoothed.
  - miss -> miss_cnt+1. If miss_cnt+1 == LOST_FRAMES -> SEARCH, lost_event pulse, miss_cnt=0.
- Smoothing (LOCKED/COAST hits only):
  - track_x <= (track_x + target_x) >> 1, using a 9-bit sum and floor; same for y with an 8-bit sum.
  - Results stay within 0..159 / 0..119 by construction.
- locked_frames: increments on every evaluated frame whose pre-transition state is LOCKED or COAST. Never clears except on reset.
- calc_done asserted on consecutive cycles: each pulse is a separate frame evaluation (no minimum spacing).
- Inputs other than enable/force_release are don't-care when calc_done=0.

Test Plan:
1. Reset, enable=1, eight calc_done pulses with target (80,60) valid:
   - lock_state goes 1 after pulse 1.
   - Goes 2 one cycle after pulse 8; lock_event high for exactly 1 cycle.
   - track = (80,60).
2. From LOCKED at (80,60), hit at (90,70):
   - track becomes (85,65).
   - Next hit at (100,60) is a miss (dx=15 > 12) -> COAST, track holds (85,65).
3. LOCKED, then 4 consecutive frames with target_valid=0:
   - States LOCKED->COAST->COAST->COAST->SEARCH.
   - lost_event pulses once, after the 4th.
   - track_valid=0 and lock_on=0 afterwards.
4. COAST with miss_cnt=2, then a hit at the track position:
   - Returns to LOCKED; miss_cnt clears.
   - A subsequent 3 misses do not drop the lock; the 4th does.
5. ACQUIRE at acq_cnt=5, frame with target_valid=0:
   - Returns to SEARCH; no lock_event.
   - Next valid target restarts at acq_cnt=1.
6. LOCKED, force_release and calc_done in the same cycle:
   - SEARCH next cycle; lost_event once; locked_frames unchanged by that pulse.
   - Repeat with enable=0 instead: SEARCH, no lost_event.
   - Assert reset mid-ACQUIRE: all outputs 0 on the next edge.

Source files
------------

// File: rtl/lock_track_controller.sv
// Per-frame lock-on controller: qualifies tracker centroids with acquisition
// hysteresis, a per-axis jump gate and coast-on-miss, and publishes a smoothed track.
module lock_track_controller #(
  parameter int ACQ_FRAMES  = 8,
  parameter int LOST_FRAMES = 4,
  parameter int MAX_JUMP    = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        force_release,
  input  logic        calc_done,
  input  logic        target_valid,
  input  logic [7:0]  target_x,
  input  logic [6:0]  target_y,
  output logic [1:0]  lock_state,
  output logic        lock_on,
  output logic        track_valid,
  output logic [7:0]  track_x,
  output logic [6:0]  track_y,
  output logic        lock_event,
  output logic        lost_event,
  output logic [15:0] locked_frames
);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_COAST   = 2'd3
  } state_t;

  localparam logic [3:0] ACQ_LIM  = 4'(ACQ_FRAMES);
  localparam logic [3:0] LOST_LIM = 4'(LOST_FRAMES);
  localparam logic [8:0] JUMP_LIM = 9'(MAX_JUMP);

  state_t      state_q, state_d;
  logic [3:0]  acq_cnt_q, acq_cnt_d;
  logic [3:0]  miss_cnt_q, miss_cnt_d;
  logic [7:0]  track_x_q, track_x_d;
  logic [6:0]  track_y_q, track_y_d;
  logic        lock_event_q, lock_event_d;
  logic        lost_event_q, lost_event_d;
  logic [15:0] locked_frames_q, locked_frames_d;

  logic [8:0]  tx9, kx9, ty9, ky9, dx, dy;
  logic [8:0]  sum_x;
  logic [7:0]  sum_y;
  logic [3:0]  acq_inc, miss_inc;
  logic        is_locked, gate_ok, hit;

  always_comb begin
    tx9 = {1'b0, target_x};
    kx9 = {1'b0, track_x_q};
    ty9 = {2'b00, target_y};
    ky9 = {2'b00, track_y_q};
    dx  = (tx9 >= kx9) ? (tx9 - kx9) : (kx9 - tx9);
    dy  = (ty9 >= ky9) ? (ty9 - ky9) : (ky9 - ty9);
    gate_ok   = (dx <= JUMP_LIM) && (dy <= JUMP_LIM);
    is_locked = (state_q == ST_LOCKED) || (state_q == ST_COAST);
    // SEARCH has no valid track to gate against, so any target is accepted
    hit      = target_valid && ((state_q == ST_SEARCH) || gate_ok);
    sum_x    = {1'b0, track_x_q} + {1'b0, target_x};
    sum_y    = {1'b0, track_y_q} + {1'b0, target_y};
    acq_inc  = acq_cnt_q + 4'd1;
    miss_inc = miss_cnt_q + 4'd1;

    state_d         = state_q;
    acq_cnt_d       = acq_cnt_q;
    miss_cnt_d      = miss_cnt_q;
    track_x_d       = track_x_q;
    track_y_d       = track_y_q;
    lock_event_d    = 1'b0;
    lost_event_d    = 1'b0;
    locked_frames_d = locked_frames_q;

    if (!enable) begin
      state_d    = ST_SEARCH;
      acq_cnt_d  = 4'd0;
      miss_cnt_d = 4'd0;
    end else if (force_release) begin
      state_d      = ST_SEARCH;
      acq_cnt_d    = 4'd0;
      miss_cnt_d   = 4'd0;
      lost_event_d = is_locked;
    end else if (calc_done) begin
      if (is_locked && (locked_frames_q != 16'hFFFF))
        locked_frames_d = locked_frames_q + 16'd1;
      case (state_q)
        ST_SEARCH: begin
          if (hit) begin
            state_d   = ST_ACQUIRE;
            acq_cnt_d = 4'd1;
            track_x_d = target_x;
            track_y_d = target_y;
          end
        end
        ST_ACQUIRE: begin
          if (hit) begin
            track_x_d = target_x;
            track_y_d = target_y;
            if (acq_inc == ACQ_LIM) begin
              state_d      = ST_LOCKED;
              acq_cnt_d    = 4'd0;
              lock_event_d = 1'b1;
            end else begin
              acq_cnt_d = acq_inc;
            end
          end else begin
            state_d   = ST_SEARCH;
            acq_cnt_d = 4'd0;
          end
        end
        ST_LOCKED: begin
          if (hit) begin
            track_x_d = sum_x[8:1];
            track_y_d = sum_y[7:1];
          end else begin
            state_d    = ST_COAST;
            miss_cnt_d = 4'd1;
          end
        end
        ST_COAST: begin
          if (hit) begin
            state_d    = ST_LOCKED;
            miss_cnt_d = 4'd0;
            track_x_d  = sum_x[8:1];
            track_y_d  = sum_y[7:1];
          end else if (miss_inc == LOST_LIM) begin
            state_d      = ST_SEARCH;
            miss_cnt_d   = 4'd0;
            lost_event_d = 1'b1;
          end else begin
            miss_cnt_d = miss_inc;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_SEARCH;
      acq_cnt_q       <= 4'd0;
      miss_cnt_q      <= 4'd0;
      track_x_q       <= 8'd0;
      track_y_q       <= 7'd0;
      lock_event_q    <= 1'b0;
      lost_event_q    <= 1'b0;
      locked_frames_q <= 16'd0;
    end else begin
      state_q         <= state_d;
      acq_cnt_q       <= acq_cnt_d;
      miss_cnt_q      <= miss_cnt_d;
      track_x_q       <= track_x_d;
      track_y_q       <= track_y_d;
      lock_event_q    <= lock_event_d;
      lost_event_q    <= lost_event_d;
      locked_frames_q <= locked_frames_d;
    end
  end

  assign lock_state    = state_q;
  assign lock_on       = (state_q == ST_LOCKED) || (state_q == ST_COAST);
  assign track_valid   = (state_q != ST_SEARCH);
  assign track_x       = track_x_q;
  assign track_y       = track_y_q;
  assign lock_event    = lock_event_q;
  assign lost_event    = lost_event_q;
  assign locked_frames = locked_frames_q;

endmodule

// File: tb/tb_lock_track_controller.sv
// Bench for lock_track_controller: directed lock/coast/release scenarios plus
// randomized traffic compared each cycle against a rule-level reference model.
module tb_lock_track_controller;

  localparam int ACQ_FRAMES  = 8;
  localparam int LOST_FRAMES = 4;
  localparam int MAX_JUMP    = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        force_release = 1'b0;
  logic        calc_done = 1'b0;
  logic        target_valid = 1'b0;
  logic [7:0]  target_x = 8'd0;
  logic [6:0]  target_y = 7'd0;
  logic [1:0]  lock_state;
  logic        lock_on, track_valid, lock_event, lost_event;
  logic [7:0]  track_x;
  logic [6:0]  track_y;
  logic [15:0] locked_frames;

  int checks = 0;
  int errors = 0;

  lock_track_controller #(
    .ACQ_FRAMES(ACQ_FRAMES), .LOST_FRAMES(LOST_FRAMES), .MAX_JUMP(MAX_JUMP)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .force_release(force_release),
    .calc_done(calc_done), .target_valid(target_valid),
    .target_x(target_x), .target_y(target_y),
    .lock_state(lock_state), .lock_on(lock_on), .track_valid(track_valid),
    .track_x(track_x), .track_y(track_y), .lock_event(lock_event),
    .lost_event(lost_event), .locked_frames(locked_frames)
  );

  always #20 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state as a plain number, counters and track as integers.
  int m_state = 0, m_acq = 0, m_miss = 0, m_tx = 0, m_ty = 0, m_lf = 0;
  int m_lock_ev = 0, m_lost_ev = 0;
  bit model_ready = 1'b0;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_step();
    bit hit, was_locked;
    m_lock_ev = 0;
    m_lost_ev = 0;
    if (reset) begin
      m_state = 0; m_acq = 0; m_miss = 0; m_tx = 0; m_ty = 0; m_lf = 0;
      model_ready = 1'b1;
    end else if (!enable) begin
      m_state = 0; m_acq = 0; m_miss = 0;
    end else if (force_release) begin
      if (m_state >= 2) m_lost_ev = 1;
      m_state = 0; m_acq = 0; m_miss = 0;
    end else if (calc_done) begin
      was_locked = (m_state >= 2);
      hit = target_valid && (m_state == 0 ||
            (iabs(int'(target_x) - m_tx) <= MAX_JUMP &&
             iabs(int'(target_y) - m_ty) <= MAX_JUMP));
      if (was_locked && m_lf < 65535) m_lf++;
      if (m_state == 0) begin
        if (hit) begin m_state = 1; m_acq = 1; m_tx = target_x; m_ty = target_y; end
      end else if (m_state == 1) begin
        if (hit) begin
          m_tx = target_x; m_ty = target_y;
          if (m_acq + 1 == ACQ_FRAMES) begin m_state = 2; m_acq = 0; m_lock_ev = 1; end
          else m_acq++;
        end else begin
          m_state = 0; m_acq = 0;
        end
      end else begin
        if (hit) begin
          m_state = 2; m_miss = 0;
          m_tx = (m_tx + target_x) / 2; m_ty = (m_ty + target_y) / 2;
        end else if (m_state == 2) begin
          m_state = 3; m_miss = 1;
        end else if (m_miss + 1 == LOST_FRAMES) begin
          m_state = 0; m_miss = 0; m_lost_ev = 1;
        end else begin
          m_miss++;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    if (model_ready) begin
      check("m_state", lock_state, m_state);
      check("m_lock_on", lock_on, (m_state >= 2) ? 1 : 0);
      check("m_track_valid", track_valid, (m_state != 0) ? 1 : 0);
      check("m_track_x", track_x, m_tx);
      check("m_track_y", track_y, m_ty);
      check("m_lock_event", lock_event, m_lock_ev);
      check("m_lost_event", lost_event, m_lost_ev);
      check("m_locked_frames", locked_frames, m_lf);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic frame(input bit v, input int x, input int y);
    calc_done = 1'b1; target_valid = v;
    target_x = 8'(x); target_y = 7'(y);
    tick();
    calc_done = 1'b0; target_valid = 1'b0;
  endtask

  task automatic lock_at(input int x, input int y);
    for (int i = 0; i < ACQ_FRAMES; i++) frame(1'b1, x, y);
  endtask

  int lf_save;

  initial begin
    reset = 1'b1;
    tick(); tick();
    check("reset_state", lock_state, 0);
    check("reset_track", {track_x, 1'b0, track_y}, 0);
    check("reset_lf", locked_frames, 0);
    reset = 1'b0; enable = 1'b1;
    tick();

    // acquisition to lock at (80,60)
    for (int i = 1; i <= ACQ_FRAMES; i++) begin
      frame(1'b1, 80, 60);
      if (i == 1) check("tp1_acq_after_1", lock_state, 1);
      if (i == ACQ_FRAMES - 1) check("tp1_acq_before_lock", lock_state, 1);
    end
    check("tp1_locked", lock_state, 2);
    check("tp1_lock_event", lock_event, 1);
    check("tp1_track_x", track_x, 80);
    check("tp1_track_y", track_y, 60);
    tick();
    check("tp1_lock_event_cleared", lock_event, 0);

    // smoothing and jump gate
    frame(1'b1, 90, 70);
    check("tp2_smooth_x", track_x, 85);
    check("tp2_smooth_y", track_y, 65);
    frame(1'b1, 100, 60);
    check("tp2_jump_coast", lock_state, 3);
    check("tp2_hold_x", track_x, 85);

    // coast recovery then drop on fourth miss
    frame(1'b0, 0, 0);
    frame(1'b1, 85, 65);
    check("tp4_relock", lock_state, 2);
    for (int i = 0; i < 3; i++) frame(1'b0, 0, 0);
    check("tp4_three_misses_coast", lock_state, 3);
    frame(1'b0, 0, 0);
    check("tp4_fourth_drops", lock_state, 0);
    check("tp4_lost_event", lost_event, 1);
    check("tp4_locked_frames", locked_frames, 8);

    // plain miss run from LOCKED
    lock_at(80, 60);
    for (int i = 1; i <= LOST_FRAMES; i++) begin
      frame(1'b0, 0, 0);
      if (i < LOST_FRAMES) begin
        check("tp3_coast", lock_state, 3);
        check("tp3_no_lost_yet", lost_event, 0);
      end
    end
    check("tp3_search", lock_state, 0);
    check("tp3_lost_event", lost_event, 1);
    check("tp3_lock_on", lock_on, 0);
    check("tp3_track_valid", track_valid, 0);
    tick();
    check("tp3_lost_single", lost_event, 0);

    // acquire abort and restart at count 1
    for (int i = 0; i < 5; i++) frame(1'b1, 50, 50);
    frame(1'b0, 0, 0);
    check("tp5_abort_search", lock_state, 0);
    check("tp5_no_lock_event", lock_event, 0);
    frame(1'b1, 50, 50);
    for (int i = 0; i < ACQ_FRAMES - 2; i++) frame(1'b1, 50, 50);
    check("tp5_still_acquire", lock_state, 1);
    frame(1'b1, 50, 50);
    check("tp5_locked", lock_state, 2);

    // force_release overrides calc_done
    lf_save = locked_frames;
    force_release = 1'b1;
    frame(1'b1, 50, 50);
    force_release = 1'b0;
    check("tp6_release_search", lock_state, 0);
    check("tp6_release_lost", lost_event, 1);
    check("tp6_release_lf", locked_frames, lf_save);
    tick();
    check("tp6_release_lost_single", lost_event, 0);

    // enable low: silent drop
    lock_at(50, 50);
    enable = 1'b0;
    frame(1'b1, 50, 50);
    check("tp6_disable_search", lock_state, 0);
    check("tp6_disable_no_lost", lost_event, 0);
    check("tp6_disable_track_hold", track_x, 50);
    enable = 1'b1;

    // gate boundary: distance 12 accepted, 13 rejected
    lock_at(80, 60);
    frame(1'b1, 92, 48);
    check("gate_edge_hit", lock_state, 2);
    check("gate_edge_x", track_x, 86);
    check("gate_edge_y", track_y, 54);
    frame(1'b1, 73, 54);
    check("gate_over_coast", lock_state, 3);

    // reset mid-acquire
    tick();
    for (int i = 0; i < 3; i++) frame(1'b1, 30, 30);
    enable = 1'b0; tick(); enable = 1'b1;
    for (int i = 0; i < 3; i++) frame(1'b1, 30, 30);
    reset = 1'b1;
    tick();
    check("rst_mid_state", lock_state, 0);
    check("rst_mid_outputs", {track_valid, lock_on, lock_event, lost_event}, 0);
    check("rst_mid_track", {track_x, 1'b0, track_y}, 0);
    check("rst_mid_lf", locked_frames, 0);
    reset = 1'b0;
    tick();

    // randomized traffic, checked by the per-cycle model compare
    for (int i = 0; i < 4000; i++) begin
      reset         = ($urandom_range(0, 599) == 0);
      enable        = ($urandom_range(0, 39) != 0);
      force_release = ($urandom_range(0, 49) == 0);
      calc_done     = ($urandom_range(0, 2) != 0);
      target_valid  = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 9) == 0) begin
        target_x = 8'($urandom_range(0, 159));
        target_y = 7'($urandom_range(0, 119));
      end else begin
        target_x = 8'($urandom_range(66, 94));
        target_y = 7'($urandom_range(46, 74));
      end
      tick();
    end
    reset = 1'b0; enable = 1'b1; force_release = 1'b0; calc_done = 1'b0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
